// File: rtl/umi_mem_responder_pkg.sv
// Shared UMI bundle types and constants for the memory-end responder.
package umi_mem_responder_pkg;

    localparam int UMI_LINE_BYTES = 64;

    typedef struct packed {
        logic        valid;
        logic        isWrite;
        logic [63:0] addr;
        logic [63:0] size;
    } UMIReq;

    typedef struct packed {
        logic         valid;
        logic [511:0] data;
    } UMIWriteData;

    typedef struct packed {
        logic         valid;
        logic [511:0] data;
    } UMIReadData;

    typedef enum logic {
        INIT,
        RUN
    } RespState_t;

    function automatic logic isBadSize(input logic [63:0] size);
        return size != 64'(UMI_LINE_BYTES);
    endfunction

endpackage

// File: rtl/umi_fifo.sv
// Synchronous FIFO with first-word fall-through head.
module umi_fifo #(
    parameter int WIDTH     = 512,
    parameter int LOG_DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] headData,
    output logic             empty,
    output logic             full
);

    localparam int DEPTH = 2**LOG_DEPTH;

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [LOG_DEPTH:0] wrPtr;
    logic [LOG_DEPTH:0] rdPtr;
    logic               doPush;
    logic               doPop;

    // Extra pointer bit distinguishes full from empty.
    assign empty = wrPtr == rdPtr;
    assign full = (wrPtr[LOG_DEPTH] != rdPtr[LOG_DEPTH]) &&
                  (wrPtr[LOG_DEPTH-1:0] == rdPtr[LOG_DEPTH-1:0]);
    assign doPush = push && !full;
    assign doPop = pop && !empty;
    assign headData = mem[rdPtr[LOG_DEPTH-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr[LOG_DEPTH-1:0]] <= pushData;
        end
    end

endmodule

// File: rtl/umi_line_ram.sv
// Simple dual-port line RAM: one write port, one registered read port.
module umi_line_ram #(
    parameter int LOG_LINES = 10,
    parameter int WIDTH     = 512
) (
    input  logic                 clk,
    input  logic                 wrEn,
    input  logic [LOG_LINES-1:0] wrAddr,
    input  logic [WIDTH-1:0]     wrData,
    input  logic                 rdEn,
    input  logic [LOG_LINES-1:0] rdAddr,
    output logic [WIDTH-1:0]     rdData
);

    logic [WIDTH-1:0] mem [2**LOG_LINES];

    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
        if (rdEn) begin
            rdData <= mem[rdAddr];
        end
    end

endmodule

// File: rtl/umi_mem_responder.sv
// UMI memory-end responder: clears RAM, grants requests in order and
// returns read lines through a credit-managed response FIFO.
module umi_mem_responder
    import umi_mem_responder_pkg::*;
#(
    parameter int LOG_LINES      = 10,
    parameter int RESP_LOG_DEPTH = 2,
    parameter bit INIT_CLEAR     = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  UMIReq       umi_req_in,
    output logic        umi_req_grant_out,
    input  UMIWriteData umi_write_in,
    output logic        umi_write_ready_out,
    output UMIReadData  umi_read_out,
    input  logic        umi_read_grant_in,
    output logic        init_done_out,
    output logic [15:0] bad_size_cnt_out
);

    localparam logic [RESP_LOG_DEPTH:0] CREDITS =
        (RESP_LOG_DEPTH + 1)'(2**RESP_LOG_DEPTH);

    RespState_t              state;
    RespState_t              stateNext;
    logic [LOG_LINES-1:0]    clearPtr;
    logic [LOG_LINES-1:0]    clearPtrNext;
    logic [LOG_LINES-1:0]    reqLine;
    logic [RESP_LOG_DEPTH:0] outstanding;
    logic [15:0]             badCnt;
    logic                    writeGrant;
    logic                    readGrant;
    logic                    rdPend;
    logic                    pop;
    logic                    fifoEmpty;
    logic                    fifoFull;
    logic                    ramWrEn;
    logic [LOG_LINES-1:0]    ramWrAddr;
    logic [511:0]            ramWrData;
    logic [511:0]            ramRdData;
    logic [511:0]            headData;
    logic                    unusedAddrBits;

    // Offset bits and everything above the line index alias onto the RAM.
    assign reqLine = umi_req_in.addr[LOG_LINES+5:6];
    assign unusedAddrBits = ^{umi_req_in.addr[5:0],
                              umi_req_in.addr[63:LOG_LINES+6]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= INIT_CLEAR ? INIT : RUN;
            clearPtr <= '0;
        end else begin
            state <= stateNext;
            clearPtr <= clearPtrNext;
        end
    end

    always_comb begin
        stateNext = state;
        clearPtrNext = clearPtr;
        writeGrant = 1'b0;
        readGrant = 1'b0;
        ramWrEn = 1'b0;
        ramWrAddr = reqLine;
        ramWrData = umi_write_in.data;
        unique case (state)
            INIT: begin
                ramWrEn = 1'b1;
                ramWrAddr = clearPtr;
                ramWrData = '0;
                clearPtrNext = clearPtr + 1'b1;
                if (&clearPtr) begin
                    stateNext = RUN;
                end
            end
            RUN: begin
                // Write grant ignores write valid: initiator derives it from grant.
                writeGrant = umi_req_in.valid && umi_req_in.isWrite;
                readGrant = umi_req_in.valid && !umi_req_in.isWrite &&
                            (outstanding < CREDITS);
                ramWrEn = writeGrant;
            end
        endcase
    end

    assign pop = umi_read_grant_in && !fifoEmpty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outstanding <= '0;
            rdPend <= 1'b0;
            badCnt <= '0;
        end else begin
            rdPend <= readGrant;
            if (readGrant && !pop) begin
                outstanding <= outstanding + 1'b1;
            end else if (!readGrant && pop) begin
                outstanding <= outstanding - 1'b1;
            end
            if ((writeGrant || readGrant) && isBadSize(umi_req_in.size) &&
                !(&badCnt)) begin
                badCnt <= badCnt + 16'd1;
            end
        end
    end

    umi_line_ram #(
        .LOG_LINES(LOG_LINES),
        .WIDTH    (512)
    ) ram (
        .clk   (clk),
        .wrEn  (ramWrEn),
        .wrAddr(ramWrAddr),
        .wrData(ramWrData),
        .rdEn  (readGrant),
        .rdAddr(reqLine),
        .rdData(ramRdData)
    );

    umi_fifo #(
        .WIDTH    (512),
        .LOG_DEPTH(RESP_LOG_DEPTH)
    ) respFifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (rdPend),
        .pushData(ramRdData),
        .pop     (pop),
        .headData(headData),
        .empty   (fifoEmpty),
        .full    (fifoFull)
    );

    assign umi_req_grant_out = writeGrant || readGrant;
    assign umi_write_ready_out = state == RUN;
    assign init_done_out = state == RUN;
    assign umi_read_out.valid = !fifoEmpty;
    assign umi_read_out.data = fifoEmpty ? '0 : headData;
    assign bad_size_cnt_out = badCnt;

    assert property (@(posedge clk) disable iff (!reset_n)
        umi_write_in.valid == writeGrant);

    assert property (@(posedge clk) disable iff (!reset_n)
        !(rdPend && fifoFull));

endmodule

// File: tb/tb_umi_mem_responder.sv
// Randomized bench for umi_mem_responder against a line-array and
// response-queue model of the UMI responder.
module tb_umi_mem_responder;
    import umi_mem_responder_pkg::*;

    localparam int LL = 4;
    localparam int RLD = 2;
    localparam int DEPTH = 4;
    localparam int NLINES = 16;

    typedef struct {
        bit           isWrite;
        logic [63:0]  addr;
        logic [63:0]  size;
        logic [511:0] data;
    } ReqItem;

    typedef struct {
        logic [511:0] data;
        int           rdy;
    } RespItem;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    UMIReq       req;
    UMIWriteData wr;
    UMIReadData  rd;
    logic        grant;
    logic        wready;
    logic        rdGrant;
    logic        initDone;
    logic [15:0] badCnt;

    ReqItem       pend[$];
    RespItem      resp[$];
    logic [511:0] mdl[NLINES];
    int           credit = 0;
    int           cyc = 0;
    int           mdlBad = 0;
    int           nCmp = 0;
    int           nBad = 0;
    int           dutGrants = 0;
    int           popPct = 70;
    bit           inRun = 0;
    bit           popEn = 0;

    always #5 clk = ~clk;

    umi_mem_responder #(
        .LOG_LINES     (LL),
        .RESP_LOG_DEPTH(RLD),
        .INIT_CLEAR    (1'b1)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .umi_req_in         (req),
        .umi_req_grant_out  (grant),
        .umi_write_in       (wr),
        .umi_write_ready_out(wready),
        .umi_read_out       (rd),
        .umi_read_grant_in  (rdGrant),
        .init_done_out      (initDone),
        .bad_size_cnt_out   (badCnt)
    );

    function automatic logic [511:0] rnd512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic void clearModel();
        pend.delete();
        resp.delete();
        credit = 0;
        mdlBad = 0;
        inRun = 0;
        for (int i = 0; i < NLINES; i++) mdl[i] = '0;
    endfunction

    task automatic addReq(input bit w, input logic [63:0] a,
                          input logic [63:0] s, input logic [511:0] d);
        ReqItem it;
        it.isWrite = w;
        it.addr = a;
        it.size = s;
        it.data = d;
        pend.push_back(it);
    endtask

    // One bus cycle: drive at negedge, observe 1ns later, advance model.
    task automatic tick();
        ReqItem h;
        bit eg;
        bit ev;
        bit pop;
        int ln;
        h = '{isWrite: 1'b0, addr: '0, size: '0, data: '0};
        @(negedge clk);
        eg = 0;
        if (pend.size() > 0) begin
            h = pend[0];
            eg = inRun && (h.isWrite || credit < DEPTH);
        end
        req.valid = pend.size() > 0;
        req.isWrite = h.isWrite;
        req.addr = h.addr;
        req.size = h.size;
        wr.valid = eg && h.isWrite;
        wr.data = h.isWrite ? h.data : '0;
        ev = resp.size() > 0 && resp[0].rdy <= cyc;
        rdGrant = popEn && ($urandom_range(1, 100) <= popPct);
        pop = ev && rdGrant;
        #1;
        if (grant === 1'b1) dutGrants++;
        nCmp++;
        if (grant !== eg)
            $display("FAIL grant cyc=%0d got=%b exp=%b", cyc, grant, eg);
        if (grant !== eg) nBad++;
        nCmp++;
        if (rd.valid !== ev) begin
            nBad++;
            $display("FAIL rdvalid cyc=%0d got=%b exp=%b", cyc, rd.valid, ev);
        end
        if (ev) begin
            nCmp++;
            if (rd.data !== resp[0].data) begin
                nBad++;
                $display("FAIL rddata cyc=%0d got=%h exp=%h", cyc,
                         rd.data[63:0], resp[0].data[63:0]);
            end
        end
        if (eg) begin
            ln = int'(h.addr[LL+5:6]);
            if (h.size != 64 && mdlBad < 65535) mdlBad++;
            if (h.isWrite) begin
                mdl[ln] = h.data;
            end else begin
                resp.push_back('{data: mdl[ln], rdy: cyc + 2});
                credit++;
            end
            void'(pend.pop_front());
        end
        if (pop) begin
            void'(resp.pop_front());
            credit--;
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic runUntilIdle(input int budget, output bit ok);
        int n = 0;
        while ((pend.size() > 0 || resp.size() > 0) && n < budget) begin
            tick();
            n++;
        end
        ok = pend.size() == 0 && resp.size() == 0;
    endtask

    task automatic releaseAndWait(output int edges);
        @(negedge clk);
        reset_n = 1'b1;
        edges = 0;
        while (edges < 64) begin
            @(posedge clk);
            cyc++;
            #1;
            edges++;
            if (initDone === 1'b1) break;
        end
        inRun = 1;
    endtask

    task automatic test_reset();
        int edges;
        bit ok;
        req = '0;
        wr = '0;
        rdGrant = 1'b0;
        clearModel();
        #2 reset_n = 1'b0;
        #1;
        nCmp++;
        if (grant !== 1'b0) begin
            nBad++; $display("FAIL rst_grant got=%b exp=0", grant);
        end
        nCmp++;
        if (wready !== 1'b0) begin
            nBad++; $display("FAIL rst_wready got=%b exp=0", wready);
        end
        nCmp++;
        if (rd !== '0) begin
            nBad++; $display("FAIL rst_read got_valid=%b exp=0", rd.valid);
        end
        nCmp++;
        if (initDone !== 1'b0) begin
            nBad++; $display("FAIL rst_initdone got=%b exp=0", initDone);
        end
        nCmp++;
        if (badCnt !== 16'd0) begin
            nBad++; $display("FAIL rst_badcnt got=%0d exp=0", badCnt);
        end
        releaseAndWait(edges);
        nCmp++;
        if (edges != NLINES) begin
            nBad++; $display("FAIL init_edges got=%0d exp=%0d", edges, NLINES);
        end
        nCmp++;
        if (wready !== 1'b1) begin
            nBad++; $display("FAIL run_wready got=%b exp=1", wready);
        end
        popEn = 1;
        popPct = 70;
        for (int i = 0; i < NLINES; i++) addReq(0, 64'(i * 64), 64, '0);
        runUntilIdle(200, ok);
        nCmp++;
        if (!ok) begin
            nBad++; $display("FAIL clear_read_timeout got=busy exp=idle");
        end
    endtask

    task automatic test_write_read();
        bit ok;
        logic [511:0] a = rnd512();
        popEn = 1;
        popPct = 100;
        addReq(1, 64'h40, 64, a);
        addReq(0, 64'h40, 64, '0);
        runUntilIdle(50, ok);
        nCmp++;
        if (!ok) begin
            nBad++; $display("FAIL wr_rd_timeout got=busy exp=idle");
        end
    endtask

    task automatic test_credit();
        bit ok;
        int g0;
        popEn = 0;
        for (int i = 0; i < 6; i++) addReq(0, 64'(i * 64), 64, '0);
        g0 = dutGrants;
        for (int i = 0; i < 10; i++) tick();
        nCmp++;
        if (dutGrants - g0 != 4) begin
            nBad++; $display("FAIL credit_grants got=%0d exp=4", dutGrants - g0);
        end
        popEn = 1;
        popPct = 100;
        runUntilIdle(60, ok);
        nCmp++;
        if (dutGrants - g0 != 6) begin
            nBad++; $display("FAIL credit_total got=%0d exp=6", dutGrants - g0);
        end
        nCmp++;
        if (!ok) begin
            nBad++; $display("FAIL credit_timeout got=busy exp=idle");
        end
    endtask

    task automatic test_bad_size();
        bit ok;
        popEn = 1;
        popPct = 80;
        addReq(1, 64'h80, 32, rnd512());
        addReq(0, 64'h80, 128, '0);
        runUntilIdle(50, ok);
        nCmp++;
        if (badCnt !== 16'd2) begin
            nBad++; $display("FAIL bad_size_cnt got=%0d exp=2", badCnt);
        end
        nCmp++;
        if (!ok) begin
            nBad++; $display("FAIL bad_size_timeout got=busy exp=idle");
        end
    endtask

    task automatic test_alias();
        bit ok;
        popEn = 1;
        popPct = 60;
        addReq(1, 64'h400, 64, rnd512());
        addReq(0, 64'h0, 64, '0);
        addReq(1, 64'hFFFF_0000_0000_047F, 64, rnd512());
        addReq(0, 64'h40, 64, '0);
        runUntilIdle(60, ok);
        nCmp++;
        if (!ok) begin
            nBad++; $display("FAIL alias_timeout got=busy exp=idle");
        end
    endtask

    task automatic test_random();
        bit ok;
        logic [63:0] sz;
        popEn = 1;
        for (int i = 0; i < 300; i++) begin
            sz = ($urandom_range(0, 7) == 0) ? {32'h0, $urandom} : 64'd64;
            addReq($urandom_range(0, 1) == 1, {$urandom, $urandom}, sz, rnd512());
            popPct = 20 + 10 * (i % 9);
            if (pend.size() > 3) tick();
        end
        runUntilIdle(2000, ok);
        nCmp++;
        if (!ok) begin
            nBad++; $display("FAIL random_timeout got=busy exp=idle");
        end
        nCmp++;
        if (badCnt !== 16'(mdlBad)) begin
            nBad++; $display("FAIL random_badcnt got=%0d exp=%0d", badCnt, mdlBad);
        end
    endtask

    task automatic test_reset_midflight();
        bit ok;
        int edges;
        popEn = 0;
        for (int i = 0; i < 3; i++) addReq(0, 64'(i * 64 + 64), 64, '0);
        for (int i = 0; i < 5; i++) tick();
        @(negedge clk);
        req = '0;
        wr = '0;
        rdGrant = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        nCmp++;
        if (rd !== '0) begin
            nBad++; $display("FAIL midrst_read got_valid=%b exp=0", rd.valid);
        end
        nCmp++;
        if (initDone !== 1'b0 || wready !== 1'b0) begin
            nBad++;
            $display("FAIL midrst_state got=%b%b exp=00", initDone, wready);
        end
        nCmp++;
        if (badCnt !== 16'd0 || grant !== 1'b0) begin
            nBad++;
            $display("FAIL midrst_cnt got=%0d/%b exp=0/0", badCnt, grant);
        end
        clearModel();
        releaseAndWait(edges);
        nCmp++;
        if (edges != NLINES) begin
            nBad++; $display("FAIL reinit_edges got=%0d exp=%0d", edges, NLINES);
        end
        popEn = 1;
        popPct = 100;
        for (int i = 0; i < 8; i++) tick();
        for (int i = 0; i < 40; i++)
            addReq($urandom_range(0, 1) == 1, {$urandom, $urandom}, 64, rnd512());
        runUntilIdle(300, ok);
        nCmp++;
        if (!ok) begin
            nBad++; $display("FAIL post_reset_timeout got=busy exp=idle");
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_credit();
        test_bad_size();
        test_alias();
        test_random();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
